// File: rtl/led_fade_pkg.sv
// Shared defaults for the LED fade driver: brightness width, full-scale
// level and the decay prescaler divisor.
package led_fade_pkg;

  localparam int N_LEDS_DEF    = 4;
  localparam int LEVEL_W_DEF   = 4;
  localparam int LEVEL_MAX_DEF = (1 << LEVEL_W_DEF) - 1;
  localparam int DECAY_DIV_DEF = 16384;

  // Width of a counter that must hold 0..div-1; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with reload/decay, and the registered
// PWM comparison that drives the pin.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_sync,
  input  logic               i_tick,
  input  logic [LEVEL_W-1:0] i_pwm_cnt,
  output logic               o_led
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  logic [LEVEL_W-1:0] r_level;
  logic               r_led;

  // A high pattern bit reloads full brightness even in a TICK cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      if (!i_enable) begin
        r_level <= '0;
      end else if (i_sync) begin
        r_level <= LEVEL_MAX;
      end else if (i_tick && (r_level != '0)) begin
        r_level <= r_level - 1'b1;
      end
      r_led <= i_enable && (i_pwm_cnt < r_level);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade driver: synchronises the scroll pattern, then lets each LED jump
// to full brightness on a set bit and decay linearly once the bit clears.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int N_LEDS    = N_LEDS_DEF,
  parameter int LEVEL_W   = LEVEL_W_DEF,
  parameter int DECAY_DIV = DECAY_DIV_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_LEDS-1:0] i_pattern,
  input  logic              i_enable,
  output logic [N_LEDS-1:0] o_led
);

  localparam int                PRE_W    = cnt_width(DECAY_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]  r_sync1;
  logic [N_LEDS-1:0]  r_sync2;
  logic [PRE_W-1:0]   r_pre;
  logic [LEVEL_W-1:0] r_pwm;
  logic               w_tick;

  // The synchroniser keeps sampling while disabled so the pattern is current on enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_pattern;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_pwm <= '0;
    end else if (!i_enable) begin
      r_pre <= '0;
      r_pwm <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_ch
      led_fade_channel #(
        .LEVEL_W(LEVEL_W)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_sync   (r_sync2[gi]),
        .i_tick   (w_tick),
        .i_pwm_cnt(r_pwm),
        .o_led    (o_led[gi])
      );
    end
  endgenerate

endmodule
